// File: rtl/ws2812_multi_if.sv
// ws2812_multi_if
// Host-side bundle for the ws2812_multi driver: colour-memory write port,
// frame request, status flags and the serial strand outputs.
//   wr_en      write strobe
//   wr_chan    target channel
//   wr_led     target LED index
//   wr_data    pixel, MSB sent first
//   start      one-shot frame request
//   busy       driver is in LOAD, DATA or GAP
//   frame_done one-cycle pulse at the end of a GAP that followed DATA
//   data_out   one serial line per strand
// master: host side; slave: driver side.
interface ws2812_multi_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_LEDS     = 8,
    parameter int BITS_PER_LED = 24
);
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int LED_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic                    wr_en;
    logic [CHAN_W-1:0]       wr_chan;
    logic [LED_W-1:0]        wr_led;
    logic [BITS_PER_LED-1:0] wr_data;
    logic                    start;
    logic                    busy;
    logic                    frame_done;
    logic [NUM_CHANNELS-1:0] data_out;

    modport master (
        output wr_en, wr_chan, wr_led, wr_data, start,
        input  busy, frame_done, data_out
    );

    modport slave (
        input  wr_en, wr_chan, wr_led, wr_data, start,
        output busy, frame_done, data_out
    );
endinterface

// File: rtl/ws2812_multi.sv
// ws2812_multi
// Multi-strand WS2812/SK6812 driver. All strands share one bit-timing engine,
// so bit boundaries line up across channels. Each channel owns a colour memory
// written through the common write port on the interface.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; enters a full reset gap
//   bus    ws2812_multi_if.slave (write port, start, busy, frame_done, data_out)
// Optional feature: define DOUBLE_BUFFER_EN to give every channel a front and
// back bank; writes land in the back bank and the banks swap at LOAD when the
// back bank has been written since the previous swap.
module ws2812_multi #(
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_LEDS     = 8,
    parameter int BITS_PER_LED = 24,
    parameter int CLK_MHZ      = 12,
    parameter int T_ON_NS      = 900,
    parameter int T_OFF_NS     = 350,
    parameter int T_PERIOD_NS  = 1250,
    parameter int T_RESET_US   = 280,
    parameter int AUTO_REFRESH = 0
) (
    input logic           clk,
    input logic           reset,
    ws2812_multi_if.slave bus
);
    localparam int T_ON     = (CLK_MHZ * T_ON_NS + 999) / 1000;
    localparam int T_OFF    = (CLK_MHZ * T_OFF_NS + 999) / 1000;
    localparam int T_PERIOD = (CLK_MHZ * T_PERIOD_NS + 999) / 1000;
    localparam int T_RESET  = CLK_MHZ * T_RESET_US;
    localparam int CNT_W    = $clog2(T_RESET + 1);
    localparam int PH_W     = (T_PERIOD > 1) ? $clog2(T_PERIOD) : 1;
    localparam int BIT_W    = $clog2(BITS_PER_LED);
    localparam int LED_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DATA, GAP} state_t;

    state_t                                     state, state_n;
    logic [CNT_W-1:0]                           gap_cnt, gap_n;
    logic [PH_W-1:0]                            phase, phase_n;
    logic [BIT_W-1:0]                           bit_idx, bit_n;
    logic [LED_W-1:0]                           led_idx, led_n;
    logic [NUM_CHANNELS-1:0][BITS_PER_LED-1:0]  shift, shift_n;
    logic [NUM_CHANNELS-1:0][BITS_PER_LED-1:0]  fetch_word;
    logic [LED_W-1:0]                           fetch_led;
    logic                                       from_data, from_n;
    logic                                       busy_q, frame_done_q;
    logic [NUM_CHANNELS-1:0]                    data_out_q, out_n;
    logic                                       wr_ok;

    // Out-of-range addresses are dropped rather than aliased onto real LEDs.
    assign wr_ok = bus.wr_en
                && (32'(bus.wr_chan) < NUM_CHANNELS)
                && (32'(bus.wr_led) < NUM_LEDS);

`ifdef DOUBLE_BUFFER_EN
    logic [BITS_PER_LED-1:0] mem [NUM_CHANNELS][2][NUM_LEDS];
    logic                    front, dirty, rd_bank, wr_bank;

    // During a swapping LOAD the new front is read immediately, and writes in
    // that same cycle already target the new back bank.
    assign rd_bank = (state == LOAD && dirty) ? ~front : front;
    assign wr_bank = ~rd_bank;

    always_ff @(posedge clk) begin
        if (reset) begin
            front <= 1'b0;
            dirty <= 1'b0;
        end else if (state == LOAD && dirty) begin
            front <= ~front;
            dirty <= wr_ok;
        end else if (wr_ok) begin
            dirty <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.wr_chan][wr_bank][bus.wr_led] <= bus.wr_data;
        end
    end
`else
    logic [BITS_PER_LED-1:0] mem [NUM_CHANNELS][NUM_LEDS];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.wr_chan][bus.wr_led] <= bus.wr_data;
        end
    end
`endif

    // The word for the next LED is read combinationally on the edge that ends
    // the current LED, so a write landing on that same edge still returns the
    // old contents. The address is clamped to 0 when no fetch is due.
    always_comb begin
        fetch_led = '0;
        if (state == DATA && led_idx != LED_W'(NUM_LEDS - 1)) begin
            fetch_led = led_idx + 1'b1;
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
`ifdef DOUBLE_BUFFER_EN
            fetch_word[c] = mem[c][rd_bank][fetch_led];
`else
            fetch_word[c] = mem[c][fetch_led];
`endif
        end
    end

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        phase_n = phase;
        bit_n   = bit_idx;
        led_n   = led_idx;
        shift_n = shift;
        from_n  = from_data;
        out_n   = '0;
        case (state)
            IDLE: begin
                if (bus.start && AUTO_REFRESH == 0) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                state_n = DATA;
                phase_n = '0;
                bit_n   = '0;
                led_n   = '0;
                shift_n = fetch_word;
            end
            DATA: begin
                if (phase == PH_W'(T_PERIOD - 1)) begin
                    phase_n = '0;
                    if (bit_idx == BIT_W'(BITS_PER_LED - 1)) begin
                        bit_n = '0;
                        if (led_idx == LED_W'(NUM_LEDS - 1)) begin
                            state_n = GAP;
                            gap_n   = CNT_W'(T_RESET);
                            from_n  = 1'b1;
                        end else begin
                            led_n   = led_idx + 1'b1;
                            shift_n = fetch_word;
                        end
                    end else begin
                        bit_n = bit_idx + 1'b1;
                        for (int c = 0; c < NUM_CHANNELS; c++) begin
                            shift_n[c] = shift[c] << 1;
                        end
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == CNT_W'(1)) begin
                    state_n = (AUTO_REFRESH != 0) ? LOAD : IDLE;
                    from_n  = 1'b0;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_n = GAP;
                gap_n   = CNT_W'(T_RESET);
                from_n  = 1'b0;
            end
        endcase
        // Line levels are computed from the next-cycle state so data_out is a
        // clean flop output that is already high in the first DATA cycle.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            out_n[c] = (state_n == DATA)
                    && (32'(phase_n) < (shift_n[c][BITS_PER_LED-1] ? T_ON : T_OFF));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= GAP;
            gap_cnt      <= CNT_W'(T_RESET);
            phase        <= '0;
            bit_idx      <= '0;
            led_idx      <= '0;
            shift        <= '0;
            from_data    <= 1'b0;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state        <= state_n;
            gap_cnt      <= gap_n;
            phase        <= phase_n;
            bit_idx      <= bit_n;
            led_idx      <= led_n;
            shift        <= shift_n;
            from_data    <= from_n;
            busy_q       <= (state_n != IDLE);
            frame_done_q <= (state_n == GAP) && (gap_n == CNT_W'(1)) && from_n;
            data_out_q   <= out_n;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.data_out   = data_out_q;
endmodule

// File: tb/tb_ws2812_multi.sv
// tb_ws2812_multi
// Directed bench for ws2812_multi. Three instances share clk/reset:
//   dut     2 channels x 2 LEDs, one-shot framing
//   dut_ar  2 channels x 2 LEDs, auto-refresh framing
//   dut_odd 3 channels x 3 LEDs, used for out-of-range write addresses
// Timing: 12 MHz, T_ON=11, T_OFF=5, T_PERIOD=15, T_RESET=12 cycles.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_ws2812_multi;
    localparam int T_PERIOD = 15;

    typedef struct {
        logic [23:0] c0l0, c0l1, c1l0, c1l1;
        int          poke_start;
        int          exp_high0, exp_high1;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ws2812_multi_if #(.NUM_CHANNELS(2), .NUM_LEDS(2), .BITS_PER_LED(24)) bus_m ();
    ws2812_multi_if #(.NUM_CHANNELS(2), .NUM_LEDS(2), .BITS_PER_LED(24)) bus_a ();
    ws2812_multi_if #(.NUM_CHANNELS(3), .NUM_LEDS(3), .BITS_PER_LED(24)) bus_o ();

    ws2812_multi #(.NUM_CHANNELS(2), .NUM_LEDS(2), .BITS_PER_LED(24), .CLK_MHZ(12),
                   .T_ON_NS(900), .T_OFF_NS(350), .T_PERIOD_NS(1250), .T_RESET_US(1),
                   .AUTO_REFRESH(0))
        dut (.clk(clk), .reset(reset), .bus(bus_m.slave));

    ws2812_multi #(.NUM_CHANNELS(2), .NUM_LEDS(2), .BITS_PER_LED(24), .CLK_MHZ(12),
                   .T_ON_NS(900), .T_OFF_NS(350), .T_PERIOD_NS(1250), .T_RESET_US(1),
                   .AUTO_REFRESH(1))
        dut_ar (.clk(clk), .reset(reset), .bus(bus_a.slave));

    ws2812_multi #(.NUM_CHANNELS(3), .NUM_LEDS(3), .BITS_PER_LED(24), .CLK_MHZ(12),
                   .T_ON_NS(900), .T_OFF_NS(350), .T_PERIOD_NS(1250), .T_RESET_US(1),
                   .AUTO_REFRESH(0))
        dut_odd (.clk(clk), .reset(reset), .bus(bus_o.slave));

    int         sel;
    logic [2:0] mon_data;
    logic       mon_busy, mon_done;

    always_comb begin
        mon_data = {1'b0, bus_m.data_out};
        mon_busy = bus_m.busy;
        mon_done = bus_m.frame_done;
        if (sel == 1) begin
            mon_data = bus_o.data_out;
            mon_busy = bus_o.busy;
            mon_done = bus_o.frame_done;
        end else if (sel == 2) begin
            mon_data = {1'b0, bus_a.data_out};
            mon_busy = bus_a.busy;
            mon_done = bus_a.frame_done;
        end
    end

    int          vectors, miscompares;
    logic        samp [3][1080];
    logic [71:0] exp_bits [3];
    int          exp_high [3];
    int          nch_cur, nleds_cur;
    int          poke_at, poke_kind;
    vec_t        vecs [4];
    int          n;

    task automatic checkOutput(input string name, input logic [71:0] actual,
                               input logic [71:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic writePixel(input int which, input int chan, input int led,
                              input logic [23:0] data);
        if (which == 1) begin
            bus_o.wr_en   = 1'b1;
            bus_o.wr_chan = 2'(chan);
            bus_o.wr_led  = 2'(led);
            bus_o.wr_data = data;
        end else begin
            bus_m.wr_en   = 1'b1;
            bus_m.wr_chan = 1'(chan);
            bus_m.wr_led  = 1'(led);
            bus_m.wr_data = data;
        end
        @(negedge clk);
        bus_m.wr_en = 1'b0;
        bus_o.wr_en = 1'b0;
    endtask

    // Reset for one edge, then expect 12 busy gap cycles with no frame_done.
    task automatic doReset(input string tag);
        int bad;
        reset = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_data_low"}, 72'(mon_data), 72'(0));
        checkOutput({tag, "_busy_done"}, 72'({mon_busy, mon_done}), 72'(2'b10));
        reset = 1'b0;
        bad = 0;
        repeat (11) begin
            @(negedge clk);
            if (mon_busy !== 1'b1 || mon_done !== 1'b0 || mon_data !== 3'b000) bad++;
        end
        checkOutput({tag, "_gap_hold"}, 72'(bad), 72'(0));
        @(negedge clk);
        checkOutput({tag, "_idle"}, 72'({mon_busy, mon_done}), 72'(0));
    endtask

    // Called with start already driven; records and decodes one whole frame.
    task automatic captureFrame(input string tag);
        int          nbits, ncyc, width, bad_shape, highs, gerr, busy_err;
        logic [71:0] got;
        @(negedge clk);
        bus_m.start = 1'b0;
        bus_a.start = 1'b0;
        bus_o.start = 1'b0;
        checkOutput({tag, "_busy_rise"}, 72'(mon_busy), 72'(1));
        checkOutput({tag, "_load_low"}, 72'(mon_data), 72'(0));
        nbits = nleds_cur * 24;
        ncyc = nbits * T_PERIOD;
        busy_err = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) samp[c][i] = mon_data[c];
            if (mon_busy !== 1'b1 || mon_done !== 1'b0) busy_err++;
            if (i == poke_at) begin
                if (poke_kind == 1) bus_m.start = 1'b1;
                if (poke_kind == 2) begin
                    bus_m.wr_en   = 1'b1;
                    bus_m.wr_chan = 1'b0;
                    bus_m.wr_led  = 1'b1;
                    bus_m.wr_data = 24'h00FF00;
                end
            end else if (i == poke_at + 1) begin
                bus_m.start = 1'b0;
                bus_m.wr_en = 1'b0;
            end
        end
        checkOutput({tag, "_data_busy"}, 72'(busy_err), 72'(0));
        for (int c = 0; c < nch_cur; c++) begin
            got = '0;
            highs = 0;
            bad_shape = 0;
            for (int k = 0; k < nbits; k++) begin
                width = 0;
                for (int j = 0; j < T_PERIOD; j++) if (samp[c][k*T_PERIOD+j]) width++;
                for (int j = 0; j < T_PERIOD; j++)
                    if (samp[c][k*T_PERIOD+j] != (j < width)) bad_shape++;
                if (width != 11 && width != 5) bad_shape++;
                got = {got[70:0], (width == 11)};
                highs += width;
            end
            checkOutput($sformatf("%s_ch%0d_bits", tag, c), got, exp_bits[c]);
            checkOutput($sformatf("%s_ch%0d_shape", tag, c), 72'(bad_shape), 72'(0));
            if (exp_high[c] >= 0)
                checkOutput($sformatf("%s_ch%0d_high", tag, c), 72'(highs), 72'(exp_high[c]));
        end
        gerr = 0;
        for (int g = 0; g < 12; g++) begin
            @(negedge clk);
            if (mon_data !== 3'b000 || mon_busy !== 1'b1 || mon_done !== (g == 11)) gerr++;
        end
        checkOutput({tag, "_gap"}, 72'(gerr), 72'(0));
        @(negedge clk);
        checkOutput({tag, "_end_idle"}, 72'({mon_busy, mon_done}), 72'(0));
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int extra;
        sel = 0;
        nch_cur = 2;
        nleds_cur = 2;
        writePixel(0, 0, 0, v.c0l0);
        writePixel(0, 0, 1, v.c0l1);
        writePixel(0, 1, 0, v.c1l0);
        writePixel(0, 1, 1, v.c1l1);
        exp_bits[0] = {24'h0, v.c0l0, v.c0l1};
        exp_bits[1] = {24'h0, v.c1l0, v.c1l1};
        exp_bits[2] = '0;
        exp_high[0] = v.exp_high0;
        exp_high[1] = v.exp_high1;
        exp_high[2] = -1;
        poke_kind = (v.poke_start >= 0) ? 1 : 0;
        poke_at = v.poke_start;
        bus_m.start = 1'b1;
        captureFrame(tag);
        if (v.poke_start >= 0) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (mon_busy !== 1'b0 || mon_data !== 3'b000) extra++;
            end
            checkOutput({tag, "_no_queued_frame"}, 72'(extra), 72'(0));
        end
        poke_at = -1;
        poke_kind = 0;
    endtask

    // Counts falling edges until dut_ar pulses frame_done; a stray start is
    // pulsed on the way and must have no effect.
    task automatic waitArDone(output int cnt);
        cnt = 0;
        while (cnt < 1000) begin
            @(negedge clk);
            cnt++;
            bus_a.start = (cnt == 50);
            if (bus_a.frame_done) break;
        end
        bus_a.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        sel = 0;
        poke_at = -1;
        poke_kind = 0;
        nch_cur = 2;
        nleds_cur = 2;
        bus_m.wr_en = 1'b0; bus_m.wr_chan = '0; bus_m.wr_led = '0; bus_m.wr_data = '0; bus_m.start = 1'b0;
        bus_a.wr_en = 1'b0; bus_a.wr_chan = '0; bus_a.wr_led = '0; bus_a.wr_data = '0; bus_a.start = 1'b0;
        bus_o.wr_en = 1'b0; bus_o.wr_chan = '0; bus_o.wr_led = '0; bus_o.wr_data = '0; bus_o.start = 1'b0;

        vecs[0] = '{24'h800001, 24'hFFFFFF, 24'h123456, 24'h000000, -1, 396, 294};
        vecs[1] = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 100, 240, 528};
        vecs[2] = '{24'hA5A5A5, 24'h5A5A5A, 24'hF0000F, 24'h00F000, -1, 384, 312};
        vecs[3] = '{24'h7FFFFE, 24'h800001, 24'h000001, 24'h800000, -1, 384, 252};

        $display("[TB] power-on reset");
        doReset("por");

        // Auto-refresh: 12 reset-gap, then LOAD + 720 DATA + 12 GAP.
        $display("[TB] auto-refresh period");
        waitArDone(n);
        checkOutput("ar_first_done", 72'(n), 72'(732));
        waitArDone(n);
        checkOutput("ar_period_1", 72'(n), 72'(733));
        waitArDone(n);
        checkOutput("ar_period_2", 72'(n), 72'(733));

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Mid-frame write to LED1 of ch0 at DATA cycle 50, before LED1 is fetched.
        $display("[TB] mid-frame write");
        writePixel(0, 0, 0, 24'h112233);
        writePixel(0, 0, 1, 24'h445566);
        writePixel(0, 1, 0, 24'h778899);
        writePixel(0, 1, 1, 24'hAABBCC);
`ifdef DOUBLE_BUFFER_EN
        exp_bits[0] = {24'h0, 24'h112233, 24'h445566};
`else
        exp_bits[0] = {24'h0, 24'h112233, 24'h00FF00};
`endif
        exp_bits[1] = {24'h0, 24'h778899, 24'hAABBCC};
        exp_high[0] = -1;
        exp_high[1] = -1;
        poke_kind = 2;
        poke_at = 50;
        bus_m.start = 1'b1;
        captureFrame("midwr_f1");
        poke_kind = 0;
        poke_at = -1;
        writePixel(0, 0, 0, 24'h112233);
        writePixel(0, 0, 1, 24'h00FF00);
        writePixel(0, 1, 0, 24'h778899);
        writePixel(0, 1, 1, 24'hAABBCC);
        exp_bits[0] = {24'h0, 24'h112233, 24'h00FF00};
        bus_m.start = 1'b1;
        captureFrame("midwr_f2");

        // Reset at DATA cycle 300.
        $display("[TB] mid-frame reset");
        bus_m.start = 1'b1;
        @(negedge clk);
        bus_m.start = 1'b0;
        repeat (300) @(negedge clk);
        doReset("midrst");

        // 3x3 instance: valid pixels plus writes at chan 3 / LED 3 that must drop.
        $display("[TB] out-of-range writes");
        sel = 1;
        nch_cur = 3;
        nleds_cur = 3;
        writePixel(1, 0, 0, 24'hC00003);
        writePixel(1, 0, 1, 24'h0F0F0F);
        writePixel(1, 0, 2, 24'h800000);
        writePixel(1, 1, 0, 24'h000001);
        writePixel(1, 1, 1, 24'hFFFF00);
        writePixel(1, 1, 2, 24'h3C3C3C);
        writePixel(1, 2, 0, 24'h555555);
        writePixel(1, 2, 1, 24'hAAAAAA);
        writePixel(1, 2, 2, 24'h010203);
        writePixel(1, 3, 0, 24'hFFFFFF);
        writePixel(1, 0, 3, 24'hFFFFFF);
        writePixel(1, 3, 3, 24'hFFFFFF);
        exp_bits[0] = {24'hC00003, 24'h0F0F0F, 24'h800000};
        exp_bits[1] = {24'h000001, 24'hFFFF00, 24'h3C3C3C};
        exp_bits[2] = {24'h555555, 24'hAAAAAA, 24'h010203};
        exp_high[0] = 462;
        exp_high[1] = -1;
        exp_high[2] = -1;
        bus_o.start = 1'b1;
        captureFrame("odd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
